// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// Includes the state enum, opcode constants, control-word struct and the opcode-to-path decode.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_R_EXEC,
    ST_R_WB,
    ST_I_EXEC,
    ST_I_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // First execution-path state for an opcode seen in DECODE; unknown opcodes trap.
  function automatic state_e op_to_state(input logic [5:0] op);
    case (op)
      OP_RTYPE:      return ST_R_EXEC;
      OP_LW, OP_SW:  return ST_MEM_ADDR;
      OP_ADDI,
      OP_ORI:        return ST_I_EXEC;
      OP_BEQ:        return ST_BRANCH;
      OP_J:          return ST_JUMP;
      default:       return ST_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Bus between the instruction register / memory / datapath and the main control FSM.
// mem_read/mem_write are requests held constant until mem_ready is seen high on a rising edge; mem_ready outside a memory phase is ignored.
interface mc_ctrl_fsm_if #(parameter int OP_W = 6);
  logic [OP_W-1:0]  opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_done;
  logic             illegal;
  mc_pkg::state_e   state;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Control-word decode: maps the current state, the latched opcode and mem_ready to datapath controls.
module mc_ctrl_decode
  import mc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH;
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      ST_I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: state register, opcode latch,
// sticky illegal flag and next-state logic; the control word comes from mc_ctrl_decode.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  mc_ctrl_fsm_if.slave bus
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;
  ctrl_t           ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = bus.opcode;
        state_d = op_to_state(bus.opcode);
      end
      // Later phases look only at the copy taken in DECODE.
      ST_MEM_ADDR: state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (bus.mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_R_WB, ST_I_WB, ST_MEM_WB,
      ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_IDLE;
    endcase
    if (state_d == ST_TRAP) illegal_d = 1'b1;
  end

  mc_ctrl_decode #(.OP_W(OP_W)) u_decode (
    .state_i     (state_q),
    .op_i        (op_q),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal       = illegal_q;
  assign bus.state         = state_q;

endmodule
